// File: rtl/sha3_iter_burst_sched_if.sv
// Handshake bundle for sha3_iter_burst_sched: input stream, round-pack link, result stream.
// The slave modport is the scheduler's view; master is the environment driving it.
interface sha3_iter_burst_sched_if #(
  parameter int STATE_W = 1600,
  parameter int ROUND_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               pk_valid;
  logic [ROUND_W-1:0] pk_round;
  logic [STATE_W-1:0] pk_state;
  logic               rt_valid;
  logic [STATE_W-1:0] rt_state;
  logic               out_valid;
  logic [STATE_W-1:0] out_state;
  logic               out_last;
  logic               busy;

  modport master (
    output in_valid, in_state, rt_valid, rt_state,
    input  in_ready, pk_valid, pk_round, pk_state, out_valid, out_state, out_last, busy
  );

  modport slave (
    input  in_valid, in_state, rt_valid, rt_state,
    output in_ready, pk_valid, pk_round, pk_state, out_valid, out_state, out_last, busy
  );
endinterface

// File: rtl/sha3_iter_burst_sched.sv
// Burst scheduler looping up to BURST Keccak states through an external PACK_ROUNDS round pack.
// Optional statistics counters are enabled with `define SHA3_ITER_BURST_STATS_EN.
module sha3_iter_burst_sched #(
  parameter int STATE_W      = 1600,
  parameter int PACK_ROUNDS  = 6,
  parameter int TOTAL_ROUNDS = 24,
  parameter int BURST        = 16,
  parameter int ROUND_W      = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sha3_iter_burst_sched_if.slave        bus
`ifdef SHA3_ITER_BURST_STATS_EN
  ,
  output logic [31:0]                   stat_bursts,
  output logic [31:0]                   stat_states,
  output logic [15:0]                   stat_drop
`endif
);

  localparam int PASSES = TOTAL_ROUNDS / PACK_ROUNDS;
  localparam int CNT_W  = $clog2(BURST + 1);
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0]  BURST_N   = CNT_W'(BURST);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  if ((TOTAL_ROUNDS % PACK_ROUNDS) != 0) begin : g_bad_rounds
    $error("TOTAL_ROUNDS must be a multiple of PACK_ROUNDS");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("BURST must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, ITER} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                in_ready_q, in_ready_d;
  logic                pk_valid_q, pk_valid_d;
  logic [ROUND_W-1:0]  pk_round_q, pk_round_d;
  logic [STATE_W-1:0]  pk_state_q, pk_state_d;
  logic                out_valid_q, out_valid_d;
  logic [STATE_W-1:0]  out_state_q, out_state_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;

  logic accept;
  logic last_ret;
  logic final_pass;

  assign accept     = bus.in_valid & in_ready_q;
  assign last_ret   = (ret_cnt_q == n_q - CNT_W'(1));
  assign final_pass = (pass_q == LAST_PASS);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    ret_cnt_d   = ret_cnt_q;
    pass_d      = pass_q;
    in_ready_d  = in_ready_q;
    pk_valid_d  = 1'b0;
    pk_round_d  = pk_round_q;
    pk_state_d  = pk_state_q;
    out_valid_d = 1'b0;
    out_state_d = out_state_q;
    out_last_d  = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        // Re-opened here, so the first new accept lands one cycle after out_last.
        in_ready_d = 1'b1;
        if (accept) begin
          pk_valid_d = 1'b1;
          pk_state_d = bus.in_state;
          pk_round_d = '0;
          n_d        = CNT_W'(1);
          ret_cnt_d  = '0;
          pass_d     = '0;
          busy_d     = 1'b1;
          if (BURST == 1) begin
            in_ready_d = 1'b0;
            state_d    = ITER;
          end else begin
            state_d    = LOAD;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          pk_valid_d = 1'b1;
          pk_state_d = bus.in_state;
          n_d        = n_q + CNT_W'(1);
          if (n_q + CNT_W'(1) == BURST_N) begin
            in_ready_d = 1'b0;
            state_d    = ITER;
          end
        end else begin
          in_ready_d = 1'b0;
          state_d    = ITER;
        end
      end

      ITER: begin
        if (bus.rt_valid) begin
          if (final_pass) begin
            out_valid_d = 1'b1;
            out_state_d = bus.rt_state;
            out_last_d  = last_ret;
          end else begin
            pk_valid_d  = 1'b1;
            pk_state_d  = bus.rt_state;
            pk_round_d  = ROUND_W'((int'(pass_q) + 1) * PACK_ROUNDS);
          end
          if (last_ret) begin
            ret_cnt_d = '0;
            if (final_pass) begin
              pass_d  = '0;
              n_d     = '0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              pass_d  = pass_q + PASS_W'(1);
            end
          end else begin
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      ret_cnt_q   <= '0;
      pass_q      <= '0;
      in_ready_q  <= 1'b1;
      pk_valid_q  <= 1'b0;
      pk_round_q  <= '0;
      pk_state_q  <= '0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      ret_cnt_q   <= ret_cnt_d;
      pass_q      <= pass_d;
      in_ready_q  <= in_ready_d;
      pk_valid_q  <= pk_valid_d;
      pk_round_q  <= pk_round_d;
      pk_state_q  <= pk_state_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.pk_valid  = pk_valid_q;
  assign bus.pk_round  = pk_round_q;
  assign bus.pk_state  = pk_state_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

`ifdef SHA3_ITER_BURST_STATS_EN
  logic [31:0] bursts_q, bursts_d;
  logic [31:0] states_q, states_d;
  logic [15:0] drop_q, drop_d;
  logic        fin_state;
  logic        fin_burst;
  logic        drop_ev;

  always_comb begin
    fin_state = (state_q == ITER) && bus.rt_valid && final_pass;
    fin_burst = fin_state && last_ret;
    drop_ev   = bus.rt_valid && (state_q != ITER);
    bursts_d  = bursts_q;
    states_d  = states_q;
    drop_d    = drop_q;
    if (fin_burst && (bursts_q != '1)) bursts_d = bursts_q + 32'd1;
    if (fin_state && (states_q != '1)) states_d = states_q + 32'd1;
    if (drop_ev   && (drop_q   != '1)) drop_d   = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bursts_q <= '0;
      states_q <= '0;
      drop_q   <= '0;
    end else begin
      bursts_q <= bursts_d;
      states_q <= states_d;
      drop_q   <= drop_d;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_states = states_q;
  assign stat_drop   = drop_q;
`endif

endmodule
